// File: rtl/discriminant_calculator_if.sv
// Job/result bundle for the ray/sphere discriminant pre-test.
// The master side (upstream) presents one sphere and one ray and reads back the result.
interface discriminant_calculator_if;
    logic signed [31:0] SphereX;
    logic signed [31:0] SphereY;
    logic signed [31:0] SphereZ;
    logic        [31:0] SphereRadius;
    logic signed [31:0] RayStartX;
    logic signed [31:0] RayStartY;
    logic signed [31:0] RayStartZ;
    logic signed [31:0] RayDirX;
    logic signed [31:0] RayDirY;
    logic signed [31:0] RayDirZ;
    logic               InputValid;
    logic               InputReady;
    logic               QuickIntersects;
    logic        [31:0] Discriminant;
    logic        [31:0] B_out;
    logic               OutputReady;

    modport master (
        output SphereX, SphereY, SphereZ, SphereRadius,
        output RayStartX, RayStartY, RayStartZ,
        output RayDirX, RayDirY, RayDirZ,
        output InputValid,
        input  InputReady, QuickIntersects, Discriminant, B_out, OutputReady
    );

    modport slave (
        input  SphereX, SphereY, SphereZ, SphereRadius,
        input  RayStartX, RayStartY, RayStartZ,
        input  RayDirX, RayDirY, RayDirZ,
        input  InputValid,
        output InputReady, QuickIntersects, Discriminant, B_out, OutputReady
    );
endinterface

// File: rtl/discriminant_calculator.sv
// Ray/sphere intersection pre-test: computes b and b^2 - 4ac of the ray-sphere
// quadratic at full precision, one job at a time, six cycles per job.
module discriminant_calculator (
    input  logic                        CLK,
    input  logic                        aresetn,
    discriminant_calculator_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, DIFF, MUL, SUM, DISC, DONE} state_t;

    state_t state;

    // Captured job (stage 0)
    logic signed [31:0] sx_p0, sy_p0, sz_p0;
    logic signed [31:0] ox_p0, oy_p0, oz_p0;
    logic signed [31:0] dx_p0, dy_p0, dz_p0;
    logic        [31:0] rad_p0;

    // L = start - centre, and R^2 (stage 1)
    logic signed [32:0] lx_p1, ly_p1, lz_p1;
    logic        [63:0] r2_p1;

    // Per-axis products (stage 2)
    logic signed [65:0] dd_x_p2, dd_y_p2, dd_z_p2;
    logic signed [65:0] dl_x_p2, dl_y_p2, dl_z_p2;
    logic signed [65:0] ll_x_p2, ll_y_p2, ll_z_p2;

    // Quadratic coefficients (stage 3)
    logic signed [67:0] a_p3;
    logic signed [68:0] b_p3;
    logic signed [68:0] c_p3;

    // Full-precision discriminant; |b^2| and |4ac| stay below 2^138
    logic signed [139:0] disc_c;

    assign disc_c = (140'(b_p3) * 140'(b_p3)) - ((140'(a_p3) * 140'(c_p3)) <<< 2);

    // Accept only when idle and out of reset
    assign bus.InputReady = (state == IDLE) && !aresetn;

    // Control FSM and registered result outputs
    always_ff @(posedge CLK) begin
        if (aresetn) begin
            state               <= IDLE;
            bus.OutputReady     <= 1'b0;
            bus.QuickIntersects <= 1'b0;
            bus.Discriminant    <= 32'd0;
            bus.B_out           <= 32'd0;
        end else begin
            bus.OutputReady <= 1'b0;
            case (state)
                IDLE: if (bus.InputValid) state <= DIFF;
                DIFF: state <= MUL;
                MUL:  state <= SUM;
                SUM:  state <= DISC;
                DISC: begin
                    bus.Discriminant    <= disc_c[31:0];
                    bus.B_out           <= b_p3[31:0];
                    bus.QuickIntersects <= (disc_c >= 140'sd0);
                    bus.OutputReady     <= 1'b1;
                    state               <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers, each stage loaded only in its own FSM state
    always_ff @(posedge CLK) begin
        // stage 0: capture the job
        if (state == IDLE && bus.InputValid) begin
            sx_p0  <= bus.SphereX;
            sy_p0  <= bus.SphereY;
            sz_p0  <= bus.SphereZ;
            rad_p0 <= bus.SphereRadius;
            ox_p0  <= bus.RayStartX;
            oy_p0  <= bus.RayStartY;
            oz_p0  <= bus.RayStartZ;
            dx_p0  <= bus.RayDirX;
            dy_p0  <= bus.RayDirY;
            dz_p0  <= bus.RayDirZ;
        end
        // stage 1: offsets and squared radius
        if (state == DIFF) begin
            lx_p1 <= 33'(ox_p0) - 33'(sx_p0);
            ly_p1 <= 33'(oy_p0) - 33'(sy_p0);
            lz_p1 <= 33'(oz_p0) - 33'(sz_p0);
            r2_p1 <= 64'(rad_p0) * 64'(rad_p0);
        end
        // stage 2: nine products; direction stays in stage 0 until the next capture
        if (state == MUL) begin
            dd_x_p2 <= 66'(dx_p0) * 66'(dx_p0);
            dd_y_p2 <= 66'(dy_p0) * 66'(dy_p0);
            dd_z_p2 <= 66'(dz_p0) * 66'(dz_p0);
            dl_x_p2 <= 66'(dx_p0) * 66'(lx_p1);
            dl_y_p2 <= 66'(dy_p0) * 66'(ly_p1);
            dl_z_p2 <= 66'(dz_p0) * 66'(lz_p1);
            ll_x_p2 <= 66'(lx_p1) * 66'(lx_p1);
            ll_y_p2 <= 66'(ly_p1) * 66'(ly_p1);
            ll_z_p2 <= 66'(lz_p1) * 66'(lz_p1);
        end
        // stage 3: a, b, c
        if (state == SUM) begin
            a_p3 <= 68'(dd_x_p2) + 68'(dd_y_p2) + 68'(dd_z_p2);
            b_p3 <= (69'(dl_x_p2) + 69'(dl_y_p2) + 69'(dl_z_p2)) <<< 1;
            c_p3 <= 69'(ll_x_p2) + 69'(ll_y_p2) + 69'(ll_z_p2) - $signed({5'b0, r2_p1});
        end
    end

endmodule

// File: tb/tb_discriminant_calculator.sv
// Directed bench for discriminant_calculator with hand-computed expectations.
module tb_discriminant_calculator;

    logic CLK;
    logic aresetn;
    int   n_checks;
    int   n_fail;

    discriminant_calculator_if bus ();

    discriminant_calculator dut (
        .CLK     (CLK),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_job(input logic signed [31:0] sx, sy, sz, input logic [31:0] r,
                             input logic signed [31:0] ox, oy, oz, dx, dy, dz);
        bus.SphereX = sx;  bus.SphereY = sy;  bus.SphereZ = sz;  bus.SphereRadius = r;
        bus.RayStartX = ox; bus.RayStartY = oy; bus.RayStartZ = oz;
        bus.RayDirX = dx;  bus.RayDirY = dy;  bus.RayDirZ = dz;
    endtask

    task automatic scramble();
        bus.SphereX = $urandom();   bus.SphereY = $urandom();   bus.SphereZ = $urandom();
        bus.SphereRadius = $urandom();
        bus.RayStartX = $urandom(); bus.RayStartY = $urandom(); bus.RayStartZ = $urandom();
        bus.RayDirX = $urandom();   bus.RayDirY = $urandom();   bus.RayDirZ = $urandom();
    endtask

    task automatic run_job(input string tag,
                           input logic signed [31:0] sx, sy, sz, input logic [31:0] r,
                           input logic signed [31:0] ox, oy, oz, dx, dy, dz,
                           input logic exp_qi, input logic [31:0] exp_disc, input logic [31:0] exp_b,
                           input bit busy_pulse);
        int waitc;
        int lat;
        drive_job(sx, sy, sz, r, ox, oy, oz, dx, dy, dz);
        bus.InputValid = 1'b1;
        waitc = 0;
        while (!bus.InputReady && waitc < 20) begin
            @(posedge CLK); #1;
            waitc++;
        end
        check({tag, " ready_before"}, 32'(bus.InputReady), 32'd1);
        @(posedge CLK); #1;               // capture edge
        bus.InputValid = 1'b0;
        scramble();
        lat = 0;
        while (!bus.OutputReady && lat < 12) begin
            check({tag, " busy"}, 32'(bus.InputReady), 32'd0);
            bus.InputValid = (busy_pulse && lat == 1) ? 1'b1 : 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        bus.InputValid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " busy_at_done"}, 32'(bus.InputReady), 32'd0);
        check({tag, " qi"}, 32'(bus.QuickIntersects), 32'(exp_qi));
        check({tag, " disc"}, bus.Discriminant, exp_disc);
        check({tag, " b"}, bus.B_out, exp_b);
        @(posedge CLK); #1;
        check({tag, " strobe_len"}, 32'(bus.OutputReady), 32'd0);
        check({tag, " ready_after"}, 32'(bus.InputReady), 32'd1);
        check({tag, " disc_hold"}, bus.Discriminant, exp_disc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        n_checks = 0;
        n_fail   = 0;
        aresetn  = 1'b1;
        bus.InputValid = 1'b0;
        drive_job(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset and release
        repeat (3) @(posedge CLK);
        #1;
        check("rst ready_in_reset", 32'(bus.InputReady), 32'd0);
        check("rst out_ready", 32'(bus.OutputReady), 32'd0);
        aresetn = 1'b0;
        #1;
        check("rst ready_release", 32'(bus.InputReady), 32'd1);
        check("rst qi", 32'(bus.QuickIntersects), 32'd0);
        check("rst disc", bus.Discriminant, 32'd0);
        check("rst b", bus.B_out, 32'd0);

        // sphere on the axis, hit
        run_job("t1", 0, 0, 0, 2, 0, 0, -10, 0, 0, 1, 1'b1, 32'd16, 32'hFFFF_FFEC, 1'b0);
        // tangent ray, disc exactly zero counts as a hit
        run_job("tangent", 0, 0, 0, 1, 1, 0, -5, 0, 0, 1, 1'b1, 32'd0, 32'hFFFF_FFF6, 1'b0);
        // disc = -2^34: low 32 bits are zero but the full value is negative
        run_job("wide", 0, 0, 0, 0, 0, 65536, 0, 1, 0, 0, 1'b0, 32'd0, 32'd0, 1'b0);
        // miss, with a busy-time valid pulse and scrambled inputs after capture
        run_job("t2", 10, -10, 10, 2, 0, 10, 0, 0, -1, 0, 1'b0, 32'hFFFF_FCF0, 32'hFFFF_FFD8, 1'b1);
        // non-normalised direction, a = 2
        run_job("t3", 10, 10, 0, 3, 0, 0, 0, 1, 1, 0, 1'b1, 32'h0000_0048, 32'hFFFF_FFD8, 1'b0);

        // reset in MUL aborts the job
        drive_job(0, 0, 0, 2, 0, 0, -10, 0, 0, 1);
        bus.InputValid = 1'b1;
        @(posedge CLK); #1;               // capture
        bus.InputValid = 1'b0;
        @(posedge CLK); #1;               // now in MUL
        aresetn = 1'b1;
        @(posedge CLK); #1;
        check("midrst ready_in_reset", 32'(bus.InputReady), 32'd0);
        check("midrst out_ready", 32'(bus.OutputReady), 32'd0);
        check("midrst qi", 32'(bus.QuickIntersects), 32'd0);
        check("midrst disc", bus.Discriminant, 32'd0);
        check("midrst b", bus.B_out, 32'd0);
        aresetn = 1'b0;
        #1;
        check("midrst ready_release", 32'(bus.InputReady), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (bus.OutputReady) seen = 1'b1;
        end
        check("midrst no_strobe", 32'(seen), 32'd0);

        // a following job completes normally
        run_job("post_rst", 0, 0, 0, 2, 0, 0, -10, 0, 0, 1, 1'b1, 32'd16, 32'hFFFF_FFEC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
